// File: rtl/bcd_seq_ctrl.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift/add-3)
// with a free-running multiplexed display scanner and leading-zero blanking.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, bin[15:0]   conversion request and operand (captured in IDLE)
//   busy, done         conversion in progress, 1-cycle completion pulse
//   bcd[19:0]          last completed result, digit 4 in [19:16]
//   digit_sel[4:0]     one-hot digit enable
//   digit_val[3:0]     BCD value of the selected digit
//   blank              selected digit is a suppressed leading zero
module bcd_seq_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic [4:0]  digit_sel,
  output logic [3:0]  digit_val,
  output logic        blank
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q;
  logic [15:0] sr_q;
  logic [19:0] acc_q;
  logic [4:0]  bit_q;
  logic        busy_q;
  logic        done_q;
  logic [19:0] bcd_q;

  logic [CW-1:0] scan_q;
  logic [2:0]    idx_q;
  logic [4:0]    sel_q;
  logic [3:0]    val_q;
  logic          blank_q;

  logic [19:0] adj;
  logic [19:0] acc_d;
  logic [15:0] sr_d;

  logic [2:0] idx_d;
  logic [4:0] sel_d;
  logic [3:0] val_d;
  logic       blank_d;

  // add-3 correction before the shift keeps each nibble in 0..9
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    {acc_d, sr_d} = {adj, sr_q} << 1;
  end

  always_comb begin
    idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    sel_d = 5'b00001 << idx_d;
    case (idx_d)
      3'd0:    val_d = bcd_q[3:0];
      3'd1:    val_d = bcd_q[7:4];
      3'd2:    val_d = bcd_q[11:8];
      3'd3:    val_d = bcd_q[15:12];
      3'd4:    val_d = bcd_q[19:16];
      default: val_d = 4'd0;
    endcase
    // blank only if this nibble and every more significant one is zero
    blank_d = (idx_d != 3'd0);
    for (int i = 0; i < 5; i++) begin
      if (i >= int'(idx_d) && bcd_q[4*i +: 4] != 4'd0)
        blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= bin;
            acc_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          acc_q <= acc_d;
          bit_q <= bit_q + 5'd1;
          if (bit_q == 5'd15) begin
            bcd_q   <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q  <= '0;
      idx_q   <= '0;
      sel_q   <= 5'b00001;
      val_q   <= '0;
      blank_q <= 1'b0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q  <= '0;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      blank_q <= blank_d;
    end else begin
      scan_q <= scan_q + CW'(1);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd       = bcd_q;
  assign digit_sel = sel_q;
  assign digit_val = val_q;
  assign blank     = blank_q;

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; clock cycles each display digit is held; legal range >= 2.
REQ-002 SHALL have port clk, input, 1; single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1; conversion request, sampled only in IDLE.
REQ-005 SHALL have port bin, input, 16; unsigned binary operand, captured on the accepted start edge.
REQ-006 SHALL have port busy, output, 1; high while a conversion is in progress.
REQ-007 SHALL have port done, output, 1; single-cycle completion pulse.
REQ-008 SHALL have port bcd, output, 20; 5-digit BCD result, digit 4 in [19:16] down to digit 0 in [3:0].
REQ-009 SHALL have port digit_sel, output, 5; one-hot, active-high display digit enable.
REQ-010 SHALL have port digit_val, output, 4; BCD value of the selected digit.
REQ-011 SHALL have port blank, output, 1; high when the selected digit is a suppressed leading zero.

Function
REQ-012 SHALL implement the converter FSM with states IDLE and SHIFT only.
REQ-013 SHALL, in IDLE with start=1 at edge k, load bin into a 16-bit shift register, clear a 20-bit working accumulator, clear the 5-bit bit counter, and enter SHIFT.
REQ-014 SHALL, in each SHIFT cycle, first add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one bit, and increment the bit counter.
REQ-015 SHALL, on the 16th SHIFT edge (edge k+16), write the final accumulator to bcd, return to IDLE, and drive done=1 for exactly the following cycle.
REQ-016 SHALL drive busy=1 from edge k through edge k+16, and busy=0 in the done cycle.
REQ-017 SHALL ignore start while in SHIFT; bin changes after edge k SHALL NOT affect the result.
REQ-018 SHALL accept start asserted during the done cycle, since the FSM is then in IDLE; minimum start-to-start period is 17 cycles.
REQ-019 SHALL hold bcd unchanged from its last completed result throughout a conversion and while idle.
REQ-020 SHALL keep every accumulator nibble within 0-9; bin=65535 SHALL yield 20'h65535.
REQ-021 SHALL run a scan counter 0..SCAN_DIV-1 freely, independent of the FSM and of busy.
REQ-022 SHALL advance digit index 0->1->2->3->4->0 on each scan counter wrap.
REQ-023 SHALL drive digit_sel = 1 << index and digit_val = bcd nibble[index], both registered and updated on the same edge as the index.
REQ-024 SHALL assert blank for index i > 0 when bcd nibbles i through 4 are all zero; digit 0 SHALL never be blanked.
REQ-025 SHALL evaluate blank against the current bcd register, so a new result takes effect at the next digit update.

Reset
REQ-026 SHALL, with rst=1 at any edge, set state IDLE, busy=0, done=0, bcd=0, scan counter=0, index=0, digit_sel=5'b00001, digit_val=0, and blank=0.
REQ-027 SHALL, on reset during SHIFT, abort the conversion and not produce a done pulse.
REQ-028 SHALL take priority for rst over start when both are high on the same edge.

Verification
REQ-029 SHALL cover: bin=16'hFFFF, start pulse at edge k -> busy high for 17 edges, done=1 for one cycle after edge k+16, bcd=20'h65535.
REQ-030 SHALL cover: bin=1234 -> bcd=20'h01234; with SCAN_DIV=2, digit 4 blanked, digits 0-3 unblanked, digit_val sequence 4,3,2,1,0.
REQ-031 SHALL cover: bin=0 -> bcd=0; digits 1-4 blanked, digit 0 shown as 0.
REQ-032 SHALL cover: start held high throughout, bin changed mid-conversion -> first result uses the captured bin, next conversion accepted in the done cycle, done pulses 17 cycles apart.
REQ-033 SHALL cover: rst asserted at the 8th SHIFT edge -> no done pulse, bcd=0, busy=0, digit_sel=5'b00001 on the following cycle.
REQ-034 SHALL cover: bin=999 then bin=1000 back-to-back -> bcd=20'h00999 then 20'h01000; every nibble <= 9 on every cycle.
